fib_index: RTL

- Inverse of the Fibonacci generator. Given a 16-bit value, it iterates the Fibonacci sequence and reports the smallest index n with fib(n) >= value.
- It also reports whether the value is exactly a Fibonacci number, and the value of fib(n).
- It sits beside the generator in the hw1 datapath, so the bench can round-trip index -> value -> index.

---
 rtl/fib_pkg.sv | 18 +
 rtl/fib_step.sv | 15 +
 rtl/fib_index.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared Fibonacci types and constants.
// Used by both the generator and the inverse (fib_index) datapaths.
package fib_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef logic [15:0] u16_t;
    typedef logic [16:0] u17_t;

    localparam u17_t FIB0    = 17'd0;
    localparam u17_t FIB1    = 17'd1;
    localparam int   MAX_IDX = 25;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci advance: (r0, r1) -> (r1, r0 + r1).
// Purely combinational; fib(26) = 121393 still fits 17 bits.
module fib_step
    import fib_pkg::*;
(
    input  u17_t r0,
    input  u17_t r1,
    output u17_t nr0,
    output u17_t nr1
);

    assign nr0 = r1;
    assign nr1 = r0 + r1;

endmodule

// File: rtl/fib_index.sv
// Inverse Fibonacci: smallest n with fib(n) >= din, plus fib(n) and exact flag.
// One compare per cycle; busy/done are registered from the state and trail it.
module fib_index
    import fib_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAX_IDX = fib_pkg::MAX_IDX
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             din,
    input  logic                         start,
    output logic [$clog2(MAX_IDX+1)-1:0] dout,
    output logic [WIDTH:0]               fib_val,
    output logic                         exact,
    output logic                         busy,
    output logic                         done
);

    localparam int IW = $clog2(MAX_IDX + 1);

    state_t          state;
    state_t          state_nx;
    logic [WIDTH:0]  target;
    u17_t            r0;
    u17_t            r1;
    u17_t            nr0;
    u17_t            nr1;
    logic [IW-1:0]   idx;
    logic            load;
    logic            hit;

    fib_step u_step (
        .r0  (r0),
        .r1  (r1),
        .nr0 (nr0),
        .nr1 (nr1)
    );

    assign hit = (r0 >= u17_t'(target));

    // Next-state decode and load strobe; start is ignored while running.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (hit) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Iteration registers: latch target on start, advance while below it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target <= '0;
            r0     <= FIB0;
            r1     <= FIB1;
            idx    <= '0;
        end else if (load) begin
            target <= din;
            r0     <= FIB0;
            r1     <= FIB1;
            idx    <= '0;
        end else if (state == S_RUN && !hit) begin
            r0     <= nr0;
            r1     <= nr1;
            idx    <= idx + 1'b1;
        end
    end

    // Result capture on the terminating compare; held until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout    <= '0;
            fib_val <= '0;
            exact   <= 1'b0;
        end else if (state == S_RUN && hit) begin
            dout    <= idx;
            fib_val <= r0;
            exact   <= (r0 == u17_t'(target));
        end
    end

    // Status flags follow the state one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state == S_RUN);
            done <= (state == S_DONE);
        end
    end

endmodule
